twiddle_cmult: RTL and testbench

Pipelined complex multiplier that sits directly downstream of the twiddle-coefficient ROM stage. Each cycle it multiplies one complex data sample by the packed 22-bit twiddle word streamed from the ROM, rounds and saturates the result back to data width, and tags output samples with frame position. It feeds the next butterfly stage of the FFT datapath.

---
 rtl/twiddle_cmult.sv | 135 +++++++++++++
 tb/tb_twiddle_cmult.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_cmult.sv
// twiddle_cmult: 4-stage pipelined complex multiplier (a+jb)*(c+jd).
// Rounds/saturates to DW and tags outputs with frame position.
// Ports: clk, rst (sync, active-high), in_valid, data_re, data_im,
//   coeff_in {c,d}; out_valid, out_re, out_im, out_first, out_last,
//   sat_flag (sticky until rst).
module twiddle_cmult #(
   parameter int DW = 16,
   parameter int CW = 11,
   parameter int N  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] data_re,
   input  logic signed [DW-1:0] data_im,
   input  logic [2*CW-1:0]      coeff_in,
   output logic                 out_valid,
   output logic signed [DW-1:0] out_re,
   output logic signed [DW-1:0] out_im,
   output logic                 out_first,
   output logic                 out_last,
   output logic                 sat_flag
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = DW + CW;
   localparam int SW = DW + CW + 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   localparam logic signed [SW-1:0] RND  = SW'(1) <<< (CW - 3);
   localparam logic signed [SW-1:0] MAXV = SW'((1 << (DW - 1)) - 1);
   localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

   logic [IW-1:0] cnt_q, cnt_d;

   logic signed [DW-1:0] a_q, b_q;
   logic signed [CW-1:0] c_q, d_q;
   logic                 v1_q, v2_q, v3_q;
   logic [IW-1:0]        i1_q, i2_q, i3_q;

   logic signed [PW-1:0] ac_q, bd_q, ad_q, bc_q;
   logic signed [SW-1:0] re_q, im_q;

   logic signed [SW-1:0] re_sh, im_sh;
   logic signed [DW-1:0] re_d, im_d;
   logic                 re_sat, im_sat;

   // Index of the sample being accepted this cycle is cnt_q itself.
   always_comb begin
      cnt_d = cnt_q;
      if (in_valid) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + IW'(1);
      end
   end

   // Round half up, then arithmetic shift back to data scale.
   always_comb begin
      re_sh  = (re_q + RND) >>> (CW - 2);
      im_sh  = (im_q + RND) >>> (CW - 2);
      re_sat = 1'b0;
      im_sat = 1'b0;
      re_d   = re_sh[DW-1:0];
      im_d   = im_sh[DW-1:0];
      if (re_sh > MAXV) begin
         re_d   = MAXV[DW-1:0];
         re_sat = 1'b1;
      end else if (re_sh < MINV) begin
         re_d   = MINV[DW-1:0];
         re_sat = 1'b1;
      end
      if (im_sh > MAXV) begin
         im_d   = MAXV[DW-1:0];
         im_sat = 1'b1;
      end else if (im_sh < MINV) begin
         im_d   = MINV[DW-1:0];
         im_sat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         v3_q      <= 1'b0;
         i1_q      <= '0;
         i2_q      <= '0;
         i3_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         d_q       <= '0;
         ac_q      <= '0;
         bd_q      <= '0;
         ad_q      <= '0;
         bc_q      <= '0;
         re_q      <= '0;
         im_q      <= '0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         // Stage 1: operand capture
         v1_q <= in_valid;
         i1_q <= cnt_q;
         a_q  <= data_re;
         b_q  <= data_im;
         c_q  <= coeff_in[2*CW-1:CW];
         d_q  <= coeff_in[CW-1:0];
         // Stage 2: partial products
         v2_q <= v1_q;
         i2_q <= i1_q;
         ac_q <= PW'(a_q) * PW'(c_q);
         bd_q <= PW'(b_q) * PW'(d_q);
         ad_q <= PW'(a_q) * PW'(d_q);
         bc_q <= PW'(b_q) * PW'(c_q);
         // Stage 3: sums
         v3_q <= v2_q;
         i3_q <= i2_q;
         re_q <= SW'(ac_q) - SW'(bd_q);
         im_q <= SW'(ad_q) + SW'(bc_q);
         // Stage 4: round/saturate to outputs
         out_valid <= v3_q;
         out_re    <= re_d;
         out_im    <= im_d;
         out_first <= v3_q && (i3_q == '0);
         out_last  <= v3_q && (i3_q == LAST);
         if (v3_q && (re_sat || im_sat)) begin
            sat_flag <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_twiddle_cmult.sv
// tb_twiddle_cmult: directed-vector bench for twiddle_cmult.
// Each task drives one scenario and checks its own results inline.
module tb_twiddle_cmult;
   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic signed [15:0] data_re;
   logic signed [15:0] data_im;
   logic [21:0]        coeff_in;
   logic               out_valid;
   logic signed [15:0] out_re;
   logic signed [15:0] out_im;
   logic               out_first;
   logic               out_last;
   logic               sat_flag;

   int n_vec = 0;
   int n_err = 0;

   twiddle_cmult #(.DW(16), .CW(11), .N(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .data_re   (data_re),
      .data_im   (data_im),
      .coeff_in  (coeff_in),
      .out_valid (out_valid),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_first (out_first),
      .out_last  (out_last),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input int a, input int b,
                         input int c, input int d);
      in_valid = v;
      data_re  = 16'(a);
      data_im  = 16'(b);
      coeff_in = {11'(c), 11'(d)};
   endtask

   task automatic do_reset;
      rst = 1'b1;
      set_in(1'b0, 0, 0, 0, 0);
      tick;
      rst = 1'b0;
   endtask

   // One sample in, then bubbles; output visible after the 4th edge.
   task automatic run_one(input int a, input int b, input int c, input int d);
      set_in(1'b1, a, b, c, d);
      tick;
      set_in(1'b0, 0, 0, 0, 0);
      tick;
      tick;
      tick;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      set_in(1'b1, 100, 100, 512, 0);
      tick;
      tick;
      n_vec++;
      if ({out_valid, out_first, out_last, sat_flag} !== 4'b0000 ||
          out_re !== 16'sd0 || out_im !== 16'sd0) begin
         n_err++;
         $display("FAIL reset: v=%b f=%b l=%b s=%b re=%0d im=%0d want all 0",
                  out_valid, out_first, out_last, sat_flag, out_re, out_im);
      end
      rst = 1'b0;
      set_in(1'b0, 0, 0, 0, 0);
   endtask

   task automatic test_identity;
      do_reset;
      run_one(1234, -567, 512, 0);
      n_vec++;
      if (out_valid !== 1'b1 || out_re !== 16'sd1234 || out_im !== -16'sd567 ||
          sat_flag !== 1'b0) begin
         n_err++;
         $display("FAIL identity: v=%b re=%0d im=%0d s=%b want 1 1234 -567 0",
                  out_valid, out_re, out_im, sat_flag);
      end
      tick;
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL identity_bubble: v=%b want 0", out_valid);
      end
   endtask

   task automatic test_rotate;
      do_reset;
      run_one(1000, 200, 0, -512);
      n_vec++;
      if (out_valid !== 1'b1 || out_re !== 16'sd200 || out_im !== -16'sd1000) begin
         n_err++;
         $display("FAIL rotate: v=%b re=%0d im=%0d want 1 200 -1000",
                  out_valid, out_re, out_im);
      end
   endtask

   task automatic test_saturation;
      do_reset;
      run_one(32767, 32767, 512, 512);
      n_vec++;
      if (out_valid !== 1'b1 || out_re !== 16'sd0 || out_im !== 16'sd32767 ||
          sat_flag !== 1'b1) begin
         n_err++;
         $display("FAIL sat: v=%b re=%0d im=%0d s=%b want 1 0 32767 1",
                  out_valid, out_re, out_im, sat_flag);
      end
      run_one(5, 6, 512, 0);
      n_vec++;
      if (out_re !== 16'sd5 || out_im !== 16'sd6 || sat_flag !== 1'b1) begin
         n_err++;
         $display("FAIL sat_sticky: re=%0d im=%0d s=%b want 5 6 1",
                  out_re, out_im, sat_flag);
      end
      run_one(-32768, 0, -512, 0);
      n_vec++;
      if (out_re !== 16'sd32767 || out_im !== 16'sd0) begin
         n_err++;
         $display("FAIL sat_neg: re=%0d im=%0d want 32767 0", out_re, out_im);
      end
      do_reset;
      n_vec++;
      if (sat_flag !== 1'b0) begin
         n_err++;
         $display("FAIL sat_clear: s=%b want 0", sat_flag);
      end
   endtask

   task automatic test_rounding;
      do_reset;
      run_one(1, 0, 256, 0);
      n_vec++;
      if (out_re !== 16'sd1 || out_im !== 16'sd0) begin
         n_err++;
         $display("FAIL round_p1: re=%0d im=%0d want 1 0", out_re, out_im);
      end
      run_one(-1, 0, 256, 0);
      n_vec++;
      if (out_re !== 16'sd0 || out_im !== 16'sd0) begin
         n_err++;
         $display("FAIL round_m1: re=%0d im=%0d want 0 0", out_re, out_im);
      end
      run_one(3, 0, 256, 0);
      n_vec++;
      if (out_re !== 16'sd2 || out_im !== 16'sd0) begin
         n_err++;
         $display("FAIL round_p3: re=%0d im=%0d want 2 0", out_re, out_im);
      end
      n_vec++;
      if (sat_flag !== 1'b0) begin
         n_err++;
         $display("FAIL round_nosat: s=%b want 0", sat_flag);
      end
   endtask

   task automatic test_framing;
      int n_in = 0;
      int n_out = 0;
      logic ef, el;
      do_reset;
      for (int s = 0; s < 80; s++) begin
         if (s < 73 && s != 10 && s != 40 && s != 66) begin
            set_in(1'b1, n_in, 0, 512, 0);
            n_in++;
         end else begin
            set_in(1'b0, 0, 0, 0, 0);
         end
         tick;
         if (out_valid === 1'b1) begin
            ef = (n_out % 32) == 0;
            el = (n_out % 32) == 31;
            n_vec++;
            if (out_re !== 16'(n_out) || out_first !== ef || out_last !== el) begin
               n_err++;
               $display("FAIL frame[%0d]: re=%0d f=%b l=%b want %0d %b %b",
                        n_out, out_re, out_first, out_last, n_out, ef, el);
            end
            n_out++;
         end else if (out_first !== 1'b0 || out_last !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_gate: f=%b l=%b while out_valid=0 want 0 0",
                     out_first, out_last);
         end
      end
      n_vec++;
      if (n_out != 70) begin
         n_err++;
         $display("FAIL frame_count: got %0d outputs want 70", n_out);
      end
   endtask

   task automatic test_back_to_back_reset;
      int n_out = 0;
      do_reset;
      for (int s = 0; s < 10; s++) begin
         set_in(1'b1, 50 + s, 0, 512, 0);
         tick;
         if (out_valid === 1'b1) n_out++;
      end
      n_vec++;
      if (n_out != 7) begin
         n_err++;
         $display("FAIL mid_pre: got %0d outputs want 7", n_out);
      end
      // Input presented while rst is high must be dropped.
      rst = 1'b1;
      set_in(1'b1, 999, 999, 512, 0);
      tick;
      rst = 1'b0;
      set_in(1'b1, 777, 0, 512, 0);
      for (int s = 0; s < 3; s++) begin
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_flush[%0d]: v=%b re=%0d want v=0",
                     s, out_valid, out_re);
         end
         tick;
         set_in(1'b0, 0, 0, 0, 0);
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_flush[3]: v=%b want 0", out_valid);
      end
      tick;
      n_vec++;
      if (out_valid !== 1'b1 || out_first !== 1'b1 || out_re !== 16'sd777) begin
         n_err++;
         $display("FAIL mid_first: v=%b f=%b re=%0d want 1 1 777",
                  out_valid, out_first, out_re);
      end
      tick;
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_after: v=%b want 0", out_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, 0, 0, 0, 0);
      test_reset;
      test_identity;
      test_rotate;
      test_saturation;
      test_rounding;
      test_framing;
      test_back_to_back_reset;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
